// File: rtl/fpu_wb_queue_if.sv
// fpu_wb_queue_if: writeback handshake bus between fpu_wb_queue and the
// shared PRF/FCR writeback port.
//   val      queue -> port   head entry valid
//   ready    port  -> queue  writeback port accepts the head this cycle
//   is_cmp   queue -> port   1 = FCR write via fcr_ptr, 0 = PRF write via dst_ptr
//   y        queue -> port   result data
//   rob_ptr  queue -> port   ROB pointer of the head result
//   dst_ptr  queue -> port   PRF destination of the head result
//   fcr_ptr  queue -> port   FCR destination of the head result
// Modports: master = the queue, slave = the writeback port.
interface fpu_wb_queue_if #(
    parameter int LG_PRF_WIDTH = 4,
    parameter int LG_ROB_WIDTH = 4,
    parameter int LG_FCR_WIDTH = 4
);
    logic                    val;
    logic                    ready;
    logic                    is_cmp;
    logic [63:0]             y;
    logic [LG_ROB_WIDTH-1:0] rob_ptr;
    logic [LG_PRF_WIDTH-1:0] dst_ptr;
    logic [LG_FCR_WIDTH-1:0] fcr_ptr;

    modport master (output val, is_cmp, y, rob_ptr, dst_ptr, fcr_ptr, input ready);
    modport slave  (input val, is_cmp, y, rob_ptr, dst_ptr, fcr_ptr, output ready);
endinterface

// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue: writeback buffer behind the non-stallable, fixed-latency FPU.
// Every arithmetic or compare result is captured into a small FIFO and drained
// to the shared writeback port over val/ready. Credits (can_issue) guarantee the
// FIFO always has room for every result already in flight.
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous, active-low reset
//   issue_start  op issued to the FPU this cycle
//   can_issue    scheduler may issue this cycle
//   flush        discard queued and in-flight results
//   fpu_val      FPU arithmetic result valid
//   fpu_cmp_val  FPU compare (FCR) result valid
//   fpu_y, fpu_rob_ptr, fpu_dst_ptr, fpu_fcr_ptr   FPU result payload
//   wb           writeback bus (fpu_wb_queue_if.master)
//   err          sticky protocol error (overflow, unexpected or double arrival)
//
// Optional feature: define FPU_WBQ_BYPASS_EN to forward an arrival straight to
// the writeback bus when the FIFO is empty and the port is ready in that cycle.
// Without it every result goes through the FIFO (one-cycle minimum latency).
module fpu_wb_queue #(
    parameter int LG_PRF_WIDTH = 4,
    parameter int LG_ROB_WIDTH = 4,
    parameter int LG_FCR_WIDTH = 4,
    parameter int FPU_LAT      = 2,
    parameter int LG_DEPTH     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_start,
    output logic                    can_issue,
    input  logic                    flush,
    input  logic                    fpu_val,
    input  logic                    fpu_cmp_val,
    input  logic [63:0]             fpu_y,
    input  logic [LG_ROB_WIDTH-1:0] fpu_rob_ptr,
    input  logic [LG_PRF_WIDTH-1:0] fpu_dst_ptr,
    input  logic [LG_FCR_WIDTH-1:0] fpu_fcr_ptr,
    fpu_wb_queue_if.master          wb,
    output logic                    err
);
    localparam int DEPTH = 1 << LG_DEPTH;
    // Wide enough for occupancy (<= DEPTH) plus in-flight count (<= FPU_LAT).
    localparam int CW    = $clog2(DEPTH + FPU_LAT + 1);

    typedef struct packed {
        logic                    is_cmp;
        logic [63:0]             y;
        logic [LG_ROB_WIDTH-1:0] rob_ptr;
        logic [LG_PRF_WIDTH-1:0] dst_ptr;
        logic [LG_FCR_WIDTH-1:0] fcr_ptr;
    } entry_t;

    // Bit i set: an accepted op delivers its result i cycles from now.
    logic [FPU_LAT-1:0] r_inflt;
    // Bit i set: the result arriving i cycles from now belongs to a flushed op.
    logic [FPU_LAT-1:0] r_kill;

    logic [LG_DEPTH:0]  wr_ptr, rd_ptr;
    entry_t             mem [DEPTH];
    entry_t             arr_entry, head;

    logic               arrival, enq_req, empty, full, deq, push, overflow;
    logic               issue_ok, err_set, bypass_take;
    logic [LG_DEPTH:0]  occ;
    logic [CW-1:0]      inflt_cnt;

    assign arrival   = fpu_val | fpu_cmp_val;
    assign arr_entry = '{is_cmp: fpu_cmp_val, y: fpu_y, rob_ptr: fpu_rob_ptr,
                         dst_ptr: fpu_dst_ptr, fcr_ptr: fpu_fcr_ptr};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LG_DEPTH] != rd_ptr[LG_DEPTH]) &&
                   (wr_ptr[LG_DEPTH-1:0] == rd_ptr[LG_DEPTH-1:0]);
    assign occ   = wr_ptr - rd_ptr;

    // Credit check uses registered state only; a dequeue in this same cycle is
    // deliberately not credited, which keeps the path off wb.ready.
    always_comb begin
        inflt_cnt = '0;
        for (int i = 0; i < FPU_LAT; i++) begin
            inflt_cnt = inflt_cnt + CW'(r_inflt[i]);
        end
        can_issue = (CW'(occ) + inflt_cnt) < CW'(DEPTH);
    end

    assign issue_ok = issue_start && can_issue && !flush;
    assign enq_req  = arrival && r_inflt[0] && !r_kill[0] && !flush;

    // Head of the FIFO drives the bus; an empty FIFO shows zeros so the bus is
    // clean after reset/flush regardless of stale RAM contents.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        head        = empty ? '0 : mem[rd_ptr[LG_DEPTH-1:0]];
        wb.val      = !empty;
        bypass_take = 1'b0;
`ifdef FPU_WBQ_BYPASS_EN
        if (empty && enq_req && wb.ready) begin
            bypass_take = 1'b1;
            head        = arr_entry;
            wb.val      = 1'b1;
        end
`endif
        wb.is_cmp  = head.is_cmp;
        wb.y       = head.y;
        wb.rob_ptr = head.rob_ptr;
        wb.dst_ptr = head.dst_ptr;
        wb.fcr_ptr = head.fcr_ptr;
    end

    assign deq      = !empty && wb.ready;
    assign push     = enq_req && !bypass_take && (!full || deq);
    assign overflow = enq_req && full && !deq;
    assign err_set  = (arrival && !r_inflt[0]) || (fpu_val && fpu_cmp_val) || overflow;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflt <= '0;
            r_kill  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err     <= 1'b0;
        end else begin
            r_inflt <= (r_inflt >> 1) | (FPU_LAT'(issue_ok) << (FPU_LAT - 1));
            // A flush marks everything still in flight (beyond this cycle's
            // arrival, which flush already blocks) as dead on arrival.
            r_kill  <= flush ? (r_inflt >> 1) : (r_kill >> 1);
            err     <= err | err_set;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (deq)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the entry RAM is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[LG_DEPTH-1:0]] <= arr_entry;
    end
endmodule

// File: tb/tb_fpu_wb_queue.sv
// Self-checking bench for fpu_wb_queue (default build). A behavioural model
// keeps the expected queue contents as a SV queue and the in-flight FPU ops as
// a list of (due cycle, killed) records; the FPU itself is modelled by the
// bench, which delivers each accepted op's result FPU_LAT cycles after issue.
module tb_fpu_wb_queue;
    localparam int LG_PRF_WIDTH = 4;
    localparam int LG_ROB_WIDTH = 4;
    localparam int LG_FCR_WIDTH = 4;
    localparam int FPU_LAT      = 2;
    localparam int LG_DEPTH     = 2;
    localparam int DEPTH        = 1 << LG_DEPTH;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_start = 1'b0;
    logic        flush = 1'b0;
    logic        fpu_val = 1'b0;
    logic        fpu_cmp_val = 1'b0;
    logic [63:0] fpu_y = '0;
    logic [3:0]  fpu_rob_ptr = '0;
    logic [3:0]  fpu_dst_ptr = '0;
    logic [3:0]  fpu_fcr_ptr = '0;
    logic        can_issue;
    logic        err;

    fpu_wb_queue_if #(.LG_PRF_WIDTH(LG_PRF_WIDTH), .LG_ROB_WIDTH(LG_ROB_WIDTH),
                      .LG_FCR_WIDTH(LG_FCR_WIDTH)) wb ();

    fpu_wb_queue #(
        .LG_PRF_WIDTH(LG_PRF_WIDTH), .LG_ROB_WIDTH(LG_ROB_WIDTH),
        .LG_FCR_WIDTH(LG_FCR_WIDTH), .FPU_LAT(FPU_LAT), .LG_DEPTH(LG_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .issue_start(issue_start), .can_issue(can_issue),
        .flush(flush), .fpu_val(fpu_val), .fpu_cmp_val(fpu_cmp_val), .fpu_y(fpu_y),
        .fpu_rob_ptr(fpu_rob_ptr), .fpu_dst_ptr(fpu_dst_ptr), .fpu_fcr_ptr(fpu_fcr_ptr),
        .wb(wb), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_cmp;
        logic [63:0] y;
        logic [3:0]  rob;
        logic [3:0]  dst;
        logic [3:0]  fcr;
    } ent_t;

    typedef struct {
        int   due;
        bit   killed;
        ent_t data;
    } op_t;

    op_t  ops[$];   // accepted ops whose result is still to arrive
    ent_t mq[$];    // expected FIFO contents, head first
    bit   m_err;
    bit   exp_can;
    int   cyc;
    ent_t nxt;      // payload of the op issued this cycle (if accepted)
    bit   inj_val;  // spurious arrival with no op behind it
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_can();
        return (mq.size() + ops.size()) < DEPTH;
    endfunction

    task automatic rand_nxt(input bit is_cmp);
        nxt.is_cmp = is_cmp;
        nxt.y      = {$urandom, $urandom};
        nxt.rob    = 4'($urandom);
        nxt.dst    = 4'($urandom);
        nxt.fcr    = 4'($urandom);
    endtask

    task automatic set_issue(input bit is_cmp, input logic [63:0] y,
                             input logic [3:0] rob, input logic [3:0] dst, input logic [3:0] fcr);
        issue_start = 1'b1;
        nxt = '{is_cmp, y, rob, dst, fcr};
    endtask

    // FPU model: present the result of the op due this cycle, if any.
    task automatic drive_fpu();
        fpu_val = 1'b0; fpu_cmp_val = 1'b0; fpu_y = '0;
        fpu_rob_ptr = '0; fpu_dst_ptr = '0; fpu_fcr_ptr = '0;
        foreach (ops[i]) begin
            if (ops[i].due == cyc) begin
                fpu_val     = !ops[i].data.is_cmp;
                fpu_cmp_val = ops[i].data.is_cmp;
                fpu_y       = ops[i].data.y;
                fpu_rob_ptr = ops[i].data.rob;
                fpu_dst_ptr = ops[i].data.dst;
                fpu_fcr_ptr = ops[i].data.fcr;
            end
        end
        if (inj_val) begin
            fpu_val = 1'b1;
            fpu_y   = {$urandom, $urandom};
        end
    endtask

    task automatic check_outputs();
        exp_can = model_can();
        check("can_issue", can_issue, exp_can);
        check("wb_val", wb.val, mq.size() != 0);
        check("err", err, m_err);
        if (mq.size() != 0) begin
            check("wb_is_cmp", wb.is_cmp, mq[0].is_cmp);
            check("wb_y", wb.y, mq[0].y);
            check("wb_rob_ptr", wb.rob_ptr, mq[0].rob);
            check("wb_dst_ptr", wb.dst_ptr, mq[0].dst);
            check("wb_fcr_ptr", wb.fcr_ptr, mq[0].fcr);
        end
    endtask

    task automatic model_update();
        int k;
        bit arrival;
        k = -1;
        foreach (ops[i]) if (ops[i].due == cyc) k = i;
        arrival = fpu_val || fpu_cmp_val;
        if (arrival && k < 0) m_err = 1'b1;
        if (fpu_val && fpu_cmp_val) m_err = 1'b1;
        if (mq.size() != 0 && wb.ready) void'(mq.pop_front());
        if (arrival && k >= 0 && !ops[k].killed && !flush) begin
            if (mq.size() < DEPTH) mq.push_back(ops[k].data);
            else m_err = 1'b1;
        end
        if (flush) begin
            mq.delete();
            foreach (ops[i]) if (ops[i].due > cyc) ops[i].killed = 1'b1;
        end
        if (issue_start && exp_can && !flush) ops.push_back('{cyc + FPU_LAT, 1'b0, nxt});
        while (ops.size() != 0 && ops[0].due <= cyc) void'(ops.pop_front());
        cyc++;
    endtask

    // One clock cycle: inputs already set by the caller.
    task automatic step();
        drive_fpu();
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_can_issue"}, can_issue, 1'b1);
        check({pfx, "_wb_val"}, wb.val, 1'b0);
        check({pfx, "_err"}, err, 1'b0);
        check({pfx, "_wb_is_cmp"}, wb.is_cmp, 1'b0);
        check({pfx, "_wb_y"}, wb.y, 64'h0);
        check({pfx, "_wb_rob"}, wb.rob_ptr, 4'h0);
        check({pfx, "_wb_dst"}, wb.dst_ptr, 4'h0);
        check({pfx, "_wb_fcr"}, wb.fcr_ptr, 4'h0);
    endtask

    initial begin
        int acc;
        checks = 0; errors = 0; cyc = 0; m_err = 1'b0; inj_val = 1'b0;
        wb.ready = 1'b0;
        rand_nxt(1'b0);

        // Reset values
        #12;
        check_reset_values("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: single arithmetic op, result one cycle after FPU arrival
        wb.ready = 1'b1;
        set_issue(1'b0, 64'h3FF0_0000_0000_0000, 4'd5, 4'd7, 4'd0);
        step();
        issue_start = 1'b0;
        step();
        check("t1_no_early_val", wb.val, 1'b0);
        step();
        check("t1_wb_val", wb.val, 1'b1);
        check("t1_wb_y", wb.y, 64'h3FF0_0000_0000_0000);
        check("t1_wb_rob", wb.rob_ptr, 4'd5);
        check("t1_wb_is_cmp", wb.is_cmp, 1'b0);
        step();

        // 2: back-pressure, credits stop after DEPTH issues, drain in order
        wb.ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            issue_start = 1'b1;
            rand_nxt(1'b0);
            if (can_issue === 1'b1) acc++;
            step();
        end
        issue_start = 1'b0;
        check("t2_credits", acc, DEPTH);
        check("t2_full_no_credit", can_issue, 1'b0);
        wb.ready = 1'b1;
        for (int n = 0; n < DEPTH + 2; n++) step();
        check("t2_no_err", err, 1'b0);

        // 3: compare op writes the FCR
        wb.ready = 1'b0;
        set_issue(1'b1, 64'h4, 4'd2, 4'd0, 4'd3);
        step();
        issue_start = 1'b0;
        step();
        step();
        check("t3_wb_is_cmp", wb.is_cmp, 1'b1);
        check("t3_wb_fcr", wb.fcr_ptr, 4'd3);
        check("t3_wb_y", wb.y, 64'h4);
        wb.ready = 1'b1;
        step();
        step();

        // 4: flush with one entry queued and two ops in flight
        wb.ready = 1'b0;
        rand_nxt(1'b0); issue_start = 1'b1;
        step();
        issue_start = 1'b0;
        step(); step();
        check("t4_one_queued", wb.val, 1'b1);
        rand_nxt(1'b0); issue_start = 1'b1;
        step();
        rand_nxt(1'b0);
        step();
        issue_start = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check("t4_wb_val_after_flush", wb.val, 1'b0);
            step();
        end
        check("t4_no_err", err, 1'b0);

        // Randomized legal traffic against the model
        for (int n = 0; n < 300; n++) begin
            flush       = ($urandom_range(0, 19) == 0);
            issue_start = !flush && ($urandom_range(0, 2) != 0) && model_can();
            rand_nxt($urandom_range(0, 3) == 0);
            wb.ready    = ($urandom_range(0, 3) != 0);
            step();
        end
        flush = 1'b0; issue_start = 1'b0; wb.ready = 1'b1;
        for (int n = 0; n < 8; n++) step();
        check("rand_no_err", err, 1'b0);

        // 5: fill to full, arrival coinciding with a dequeue, then a spurious result
        wb.ready = 1'b0;
        for (int n = 0; n < 12; n++) begin
            issue_start = model_can();
            rand_nxt(1'b0);
            step();
        end
        issue_start = 1'b0;
        check("t5_full_val", wb.val, 1'b1);
        check("t5_full_can", can_issue, 1'b0);
        wb.ready = 1'b1;
        step();
        wb.ready = 1'b0;
        rand_nxt(1'b0); issue_start = 1'b1;
        step();
        issue_start = 1'b0;
        step();
        wb.ready = 1'b1;
        step();
        wb.ready = 1'b0;
        check("t5_enq_deq_can", can_issue, 1'b1);
        check("t5_enq_deq_err", err, 1'b0);
        inj_val = 1'b1;
        step();
        inj_val = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check("t5_err_sticky", err, 1'b1);
            step();
        end

        // 6: async reset with entries queued and an op in flight
        rand_nxt(1'b0); issue_start = 1'b1;
        step();
        issue_start = 1'b0;
        check("t6_queued", wb.val, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_reset_values("t6");
        mq.delete(); ops.delete(); m_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        inj_val = 1'b1;
        step();
        inj_val = 1'b0;
        check("t6_late_arrival_err", err, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
